// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a lookup port (0) and a
// refill/update port (1); owns the zeroing sweep after reset and on flush.
module sram_arbiter #(
  parameter int unsigned DATA_W = 53,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wen,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wen,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  input  logic              flush,
  output logic              busy,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              last_grant_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;

  logic idle;
  logic grant0;
  logic grant1;

  // last_grant_q holds the index of the most recently granted port; under
  // contention the other port wins.
  assign idle   = (state_q == IDLE);
  assign grant0 = idle & ~flush & req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = idle & ~flush & req1_valid & (~req0_valid | ~last_grant_q);

  assign busy       = ~idle;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = sram_rdata;
  assign rsp1_rdata = sram_rdata;

  always_comb begin
    sram_cen   = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (!idle) begin
      sram_cen  = 1'b1;
      sram_wen  = 1'b1;
      sram_addr = clr_cnt_q;
    end else if (grant0) begin
      sram_cen   = 1'b1;
      sram_wen   = req0_wen;
      sram_addr  = req0_addr;
      sram_wdata = req0_wdata;
    end else if (grant1) begin
      sram_cen   = 1'b1;
      sram_wen   = req1_wen;
      sram_addr  = req1_addr;
      sram_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      rsp0_valid_q <= grant0 & ~req0_wen;
      rsp1_valid_q <= grant1 & ~req1_wen;
      if (grant0) last_grant_q <= 1'b0;
      else if (grant1) last_grant_q <= 1'b1;
      unique case (state_q)
        CLEAR: begin
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (flush) state_q <= CLEAR;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_sram_arbiter;

  localparam int unsigned DW = 53;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_wen;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          rsp0_valid;
  logic          req1_valid, req1_ready, req1_wen;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic          rsp1_valid;
  logic          flush, busy, sram_cen, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] mem [32];

  int errors = 0;
  int checks = 0;

  localparam logic [DW-1:0] D1 = 53'h1_2345;
  localparam logic [DW-1:0] D2 = 53'h1A_BCDE_F012_3456;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cen) begin
      if (sram_wen) mem[sram_addr] <= sram_wdata;
      else          sram_rdata     <= mem[sram_addr];
    end
  end

  sram_arbiter #(.DATA_W(53), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .flush(flush), .busy(busy),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0;
    req0_valid = 1'b1; req0_wen = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_wen = 1'b0; req1_addr = '0; req1_wdata = '0;
    @(negedge clk); #1;
    checks++;
    if ({busy, req0_ready, req1_ready, sram_cen, sram_wen, sram_addr, rsp0_valid, rsp1_valid} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h",
               {busy, req0_ready, req1_ready, sram_cen, sram_wen, sram_addr, rsp0_valid, rsp1_valid},
               {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0});
    end
    checks++;
    if (sram_wdata !== '0) begin
      errors++; $display("FAIL reset_wdata: got %h want 0", sram_wdata);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1; checks++;
      if ({busy, req0_ready, sram_cen, sram_wen, sram_addr, sram_wdata} !==
          {1'b1, 1'b0, 1'b1, 1'b1, 5'(i), 53'd0}) begin
        errors++;
        $display("FAIL reset_sweep[%0d]: got %h want %h", i,
                 {busy, req0_ready, sram_cen, sram_wen, sram_addr, sram_wdata},
                 {1'b1, 1'b0, 1'b1, 1'b1, 5'(i), 53'd0});
      end
      @(negedge clk);
    end
    #1; checks++;
    if ({busy, req0_ready, sram_cen, sram_wen} !== 4'b0110) begin
      errors++; $display("FAIL reset_first_grant: got %b want 0110", {busy, req0_ready, sram_cen, sram_wen});
    end
    @(negedge clk); req0_valid = 1'b0; #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {1'b1, 1'b0, 53'd0}) begin
      errors++; $display("FAIL reset_first_rsp: got %h want %h", {rsp0_valid, rsp1_valid, rsp0_rdata}, {1'b1, 1'b0, 53'd0});
    end
    @(negedge clk);
  endtask

  task automatic test_contention;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_wen = 1'b0; req0_addr = 5'd3;
    req1_valid = 1'b1; req1_wen = 1'b0; req1_addr = 5'd7;
    @(negedge clk); rst_n = 1'b1;
    repeat (32) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1; checks++;
      if ({req0_ready, req1_ready, sram_addr, rsp0_valid, rsp1_valid} !==
          {(k % 2 == 0), (k % 2 == 1), ((k % 2 == 0) ? 5'd3 : 5'd7), (k % 2 == 1), (k > 0 && k % 2 == 0)}) begin
        errors++;
        $display("FAIL contention[%0d]: got %h want %h", k,
                 {req0_ready, req1_ready, sram_addr, rsp0_valid, rsp1_valid},
                 {(k % 2 == 0), (k % 2 == 1), ((k % 2 == 0) ? 5'd3 : 5'd7), (k % 2 == 1), (k > 0 && k % 2 == 0)});
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, sram_cen} !== 3'b010) begin
      errors++; $display("FAIL contention_tail: got %b want 010", {rsp0_valid, rsp1_valid, sram_cen});
    end
    @(negedge clk);
  endtask

  task automatic test_write_read;
    req0_valid = 1'b1; req0_wen = 1'b1; req0_addr = 5'd5; req0_wdata = D1; #1;
    checks++;
    if ({req0_ready, req1_ready, sram_cen, sram_wen, sram_addr, sram_wdata} !== {1'b1, 1'b0, 1'b1, 1'b1, 5'd5, D1}) begin
      errors++; $display("FAIL wr_grant: got %h want %h",
                         {req0_ready, req1_ready, sram_cen, sram_wen, sram_addr, sram_wdata}, {1'b1, 1'b0, 1'b1, 1'b1, 5'd5, D1});
    end
    @(negedge clk); req0_wen = 1'b0; #1;
    checks++;
    if ({req0_ready, sram_cen, sram_wen, rsp0_valid} !== 4'b1100) begin
      errors++; $display("FAIL rd_grant: got %b want 1100", {req0_ready, sram_cen, sram_wen, rsp0_valid});
    end
    @(negedge clk); req0_valid = 1'b0; #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_rdata} !== {1'b1, 1'b0, D1}) begin
      errors++; $display("FAIL rd_rsp: got %h want %h", {rsp0_valid, rsp1_valid, rsp0_rdata}, {1'b1, 1'b0, D1});
    end
    @(negedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL rd_rsp_single: got %b want 0", rsp0_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_req;
    flush = 1'b1; req0_valid = 1'b1; req0_wen = 1'b0; req0_addr = 5'd5; #1;
    checks++;
    if ({busy, req0_ready, sram_cen} !== 3'b000) begin
      errors++; $display("FAIL flush_prio: got %b want 000", {busy, req0_ready, sram_cen});
    end
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1; checks++;
      if ({busy, req0_ready, sram_cen, sram_wen, sram_addr} !== {1'b1, 1'b0, 1'b1, 1'b1, 5'(i)}) begin
        errors++; $display("FAIL flush_sweep[%0d]: got %h want %h", i,
                           {busy, req0_ready, sram_cen, sram_wen, sram_addr}, {1'b1, 1'b0, 1'b1, 1'b1, 5'(i)});
      end
      @(negedge clk);
    end
    #1; checks++;
    if ({busy, req0_ready, sram_addr} !== {1'b0, 1'b1, 5'd5}) begin
      errors++; $display("FAIL flush_end: got %h want %h", {busy, req0_ready, sram_addr}, {1'b0, 1'b1, 5'd5});
    end
    @(negedge clk); req0_valid = 1'b0; #1;
    checks++;
    if ({rsp0_valid, rsp0_rdata} !== {1'b1, 53'd0}) begin
      errors++; $display("FAIL flush_cleared: got %h want %h", {rsp0_valid, rsp0_rdata}, {1'b1, 53'd0});
    end
    @(negedge clk);
  endtask

  task automatic test_flush_mid_sweep;
    flush = 1'b1; #1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      flush = (i == 10); #1;
      checks++;
      if ({busy, sram_addr} !== {1'b1, 5'(i)}) begin
        errors++; $display("FAIL flush_ignored[%0d]: got %h want %h", i, {busy, sram_addr}, {1'b1, 5'(i)});
      end
      @(negedge clk);
    end
    flush = 1'b0; #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_ignored_end: got busy=%b want 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep;
    req0_valid = 1'b1; req0_wen = 1'b0; req0_addr = 5'd1; #1;
    @(negedge clk); req0_valid = 1'b0; #1;
    checks++;
    if (rsp0_valid !== 1'b1) begin
      errors++; $display("FAIL pend_rsp: got %b want 1", rsp0_valid);
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({rsp0_valid, busy, sram_addr} !== {1'b0, 1'b1, 5'd0}) begin
      errors++; $display("FAIL pend_rsp_abort: got %h want %h", {rsp0_valid, busy, sram_addr}, {1'b0, 1'b1, 5'd0});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (32) @(negedge clk);
    flush = 1'b1; #1;
    @(negedge clk); flush = 1'b0;
    repeat (20) @(negedge clk);
    #1; checks++;
    if (sram_addr !== 5'd20) begin
      errors++; $display("FAIL mid_sweep_pos: got %0d want 20", sram_addr);
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({busy, sram_addr, req0_ready} !== {1'b1, 5'd0, 1'b0}) begin
      errors++; $display("FAIL mid_sweep_rst: got %h want %h", {busy, sram_addr, req0_ready}, {1'b1, 5'd0, 1'b0});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1; checks++;
      if ({busy, sram_addr} !== {1'b1, 5'(i)}) begin
        errors++; $display("FAIL restart_sweep[%0d]: got %h want %h", i, {busy, sram_addr}, {1'b1, 5'(i)});
      end
      @(negedge clk);
    end
    #1; checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL restart_end: got busy=%b want 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_read_before_flush;
    req1_valid = 1'b1; req1_wen = 1'b1; req1_addr = 5'd9; req1_wdata = D2; #1;
    checks++;
    if ({req1_ready, sram_wen, sram_wdata} !== {1'b1, 1'b1, D2}) begin
      errors++; $display("FAIL rbf_write: got %h want %h", {req1_ready, sram_wen, sram_wdata}, {1'b1, 1'b1, D2});
    end
    @(negedge clk); req1_valid = 1'b0;
    req0_valid = 1'b1; req0_wen = 1'b0; req0_addr = 5'd9; #1;
    checks++;
    if ({req0_ready, sram_addr} !== {1'b1, 5'd9}) begin
      errors++; $display("FAIL rbf_read: got %h want %h", {req0_ready, sram_addr}, {1'b1, 5'd9});
    end
    @(negedge clk); req0_valid = 1'b0; flush = 1'b1; #1;
    checks++;
    if ({busy, sram_cen, rsp0_valid, rsp0_rdata} !== {1'b0, 1'b0, 1'b1, D2}) begin
      errors++; $display("FAIL rbf_rsp: got %h want %h", {busy, sram_cen, rsp0_valid, rsp0_rdata}, {1'b0, 1'b0, 1'b1, D2});
    end
    @(negedge clk); flush = 1'b0; #1;
    checks++;
    if ({busy, rsp0_valid, sram_addr} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL rbf_clear_start: got %h want %h", {busy, rsp0_valid, sram_addr}, {1'b1, 1'b0, 5'd0});
    end
    repeat (32) @(negedge clk);
    #1; checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rbf_clear_end: got busy=%b want 0", busy);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_write_read();
    test_flush_req();
    test_flush_mid_sweep();
    test_reset_mid_sweep();
    test_read_before_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
